crt_io_seq: RTL and testbench

- Host I/O cycle sequencer in front of the CRT/extension register decode path.
- Accepts one host I/O request at a time and drives 8-bit decoder strobes (iord/iowr, io_8, address, data bus).
- In split mode, breaks each 16-bit access into two 8-bit sub-cycles: index (even address) first, then data (address+1), with a recovery gap between them.
- Waits on the decoder's active-low ready, enforces a minimum strobe width, times out hung cycles and returns an ack with assembled read data.

---
 rtl/crt_io_pkg.sv | 22 ++
 rtl/crt_io_stbtmr.sv | 37 +++
 rtl/crt_io_seq.sv | 144 ++++++++++++++
 tb/tb_crt_io_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crt_io_pkg.sv
// Shared types and constants for the CRT host I/O cycle sequencer.
// The state enum, timeout byte and counter sizing helper live here.
package crt_io_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STB,
      GAP,
      ACK
   } state_t;

   localparam logic [7:0] TIMEOUT_BYTE  = 8'hFF;
   localparam int         DEF_MIN_STB   = 2;
   localparam int         DEF_TO_CYCLES = 64;

   // Strobe counter only ever needs to reach TO_CYCLES-1.
   function automatic int cnt_width(input int to_cycles);
      return $clog2(to_cycles + 1);
   endfunction

endpackage

// File: rtl/crt_io_stbtmr.sv
// Strobe-width / timeout counter for one decoder sub-cycle.
// Counts strobe cycles while enabled; flags minimum width and timeout.
module crt_io_stbtmr
   import crt_io_pkg::*;
#(
   parameter int MIN_STB   = DEF_MIN_STB,
   parameter int TO_CYCLES = DEF_TO_CYCLES,
   parameter int CW        = cnt_width(DEF_TO_CYCLES)
) (
   input  logic h_hclk,
   input  logic h_reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_min_met,
   output logic o_timed_out
);

   localparam logic [CW-1:0] MIN_LAST = CW'(MIN_STB - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   // r_cnt holds the number of strobe cycles already completed before the current one.
   always_ff @(posedge h_hclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && (r_cnt != TO_LAST)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_min_met   = (r_cnt >= MIN_LAST);
   assign o_timed_out = (r_cnt == TO_LAST);

endmodule

// File: rtl/crt_io_seq.sv
// Host I/O cycle sequencer: turns one host request into decoder strobe
// sub-cycles (split into index/data bytes for 16-bit) and returns an ack.
module crt_io_seq
   import crt_io_pkg::*;
#(
   parameter int SPLIT16   = 1,
   parameter int MIN_STB   = DEF_MIN_STB,
   parameter int TO_CYCLES = DEF_TO_CYCLES
) (
   input  logic        h_hclk,
   input  logic        h_reset_n,
   input  logic        io_req,
   input  logic        io_wr,
   input  logic        io_size16,
   input  logic [15:0] io_addr,
   input  logic [15:0] io_wdata,
   output logic        io_ack,
   output logic [15:0] io_rdata,
   output logic        io_timeout,
   output logic        d_iord,
   output logic        d_iowr,
   output logic        d_io_8,
   output logic        d_io_16,
   output logic [15:0] d_io_addr,
   output logic [15:0] d_io_dbus,
   input  logic        d_ready_n,
   input  logic [15:0] d_rdata,
   output logic        busy
);

   localparam int CW = cnt_width(TO_CYCLES);

   state_t      r_state;
   state_t      w_next;
   logic        r_wr;
   logic        r_size16;
   logic        r_second;
   logic        r_to;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_rbuf;
   logic [15:0] r_rdata;
   logic        w_min_met;
   logic        w_timed_out;
   logic        w_ready;
   logic        w_done;
   logic        w_pass16;
   logic        w_split_acc;
   logic        w_in_seq;
   logic [7:0]  w_byte;
   logic [7:0]  w_cur;
   logic [15:0] w_rnext;

   crt_io_stbtmr #(
      .MIN_STB  (MIN_STB),
      .TO_CYCLES(TO_CYCLES),
      .CW       (CW)
   ) u_stbtmr (
      .h_hclk     (h_hclk),
      .h_reset_n  (h_reset_n),
      .i_clear    (r_state != STB),
      .i_enable   (r_state == STB),
      .o_min_met  (w_min_met),
      .o_timed_out(w_timed_out)
   );

   assign w_pass16    = (SPLIT16 == 0) && r_size16;
   assign w_split_acc = (SPLIT16 != 0) && r_size16;
   assign w_ready     = !d_ready_n && w_min_met;
   assign w_done      = w_ready || w_timed_out;
   // A sub-cycle that finishes without ready is by construction a timeout.
   assign w_byte      = w_ready ? d_rdata[7:0] : TIMEOUT_BYTE;

   always_comb begin
      w_rnext = r_rbuf;
      if (w_pass16) begin
         w_rnext = w_ready ? d_rdata : {TIMEOUT_BYTE, TIMEOUT_BYTE};
      end else if (r_second) begin
         w_rnext[15:8] = w_byte;
      end else begin
         w_rnext[7:0] = w_byte;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (io_req) w_next = SETUP;
         SETUP:   w_next = STB;
         STB:     if (w_done) w_next = (w_split_acc && !r_second) ? GAP : ACK;
         GAP:     w_next = STB;
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Request latch, byte assembly and the read-data register seen by the host.
   always_ff @(posedge h_hclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         r_state  <= IDLE;
         r_wr     <= 1'b0;
         r_size16 <= 1'b0;
         r_second <= 1'b0;
         r_to     <= 1'b0;
         r_addr   <= 16'h0;
         r_wdata  <= 16'h0;
         r_rbuf   <= 16'h0;
         r_rdata  <= 16'h0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && io_req) begin
            r_wr     <= io_wr;
            r_size16 <= io_size16;
            r_addr   <= io_addr;
            r_wdata  <= io_wdata;
            r_second <= 1'b0;
            r_to     <= 1'b0;
            r_rbuf   <= 16'h0;
         end else if (r_state == STB && w_done) begin
            r_rbuf <= w_rnext;
            r_to   <= r_to | !w_ready;
            if (w_split_acc && !r_second) begin
               r_second <= 1'b1;
            end else if (!r_wr) begin
               r_rdata <= w_rnext;
            end
         end
      end
   end

   assign w_in_seq   = (r_state == SETUP) || (r_state == STB) || (r_state == GAP);
   assign w_cur      = r_second ? r_wdata[15:8] : r_wdata[7:0];
   assign busy       = (r_state != IDLE);
   assign io_ack     = (r_state == ACK);
   assign io_timeout = (r_state == ACK) && r_to;
   assign io_rdata   = r_rdata;
   assign d_iord     = (r_state == STB) && !r_wr;
   assign d_iowr     = (r_state == STB) && r_wr;
   assign d_io_8     = w_in_seq && !w_pass16;
   assign d_io_16    = w_in_seq && w_pass16;
   assign d_io_addr  = r_addr + {15'h0, r_second};
   assign d_io_dbus  = (SPLIT16 == 0) ? r_wdata : {w_cur, w_cur};

endmodule

// File: tb/tb_crt_io_seq.sv
// Self-checking bench for crt_io_seq: directed cases plus random requests
// compared cycle by cycle against a timeline model built from the access rules.
module tb_crt_io_seq;

   localparam int MIN_STB   = 2;
   localparam int TO_CYCLES = 64;
   localparam int NEVER     = 999;
   localparam int K_SETUP   = 0;
   localparam int K_STB     = 1;
   localparam int K_GAP     = 2;
   localparam int K_ACK     = 3;

   typedef struct {
      bit          wr;
      bit          s16;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          rdly0;
      int          rdly1;
      logic [7:0]  rb0;
      logic [7:0]  rb1;
   } txn_t;

   typedef struct {
      int          kind;
      int          sub;
      int          stbNum;
      logic [15:0] addr;
      logic [7:0]  db;
   } cyc_t;

   logic        h_hclk;
   logic        h_reset_n;
   logic        io_req;
   logic        io_wr;
   logic        io_size16;
   logic [15:0] io_addr;
   logic [15:0] io_wdata;
   logic        io_ack;
   logic [15:0] io_rdata;
   logic        io_timeout;
   logic        d_iord;
   logic        d_iowr;
   logic        d_io_8;
   logic        d_io_16;
   logic [15:0] d_io_addr;
   logic [15:0] d_io_dbus;
   logic        d_ready_n;
   logic [15:0] d_rdata;
   logic        busy;

   int          testsRun;
   int          testsFailed;
   cyc_t        expQ[$];
   txn_t        cur;
   logic [15:0] curRd;
   logic        curTo;

   crt_io_seq #(
      .SPLIT16  (1),
      .MIN_STB  (MIN_STB),
      .TO_CYCLES(TO_CYCLES)
   ) dut (
      .h_hclk    (h_hclk),
      .h_reset_n (h_reset_n),
      .io_req    (io_req),
      .io_wr     (io_wr),
      .io_size16 (io_size16),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_ack    (io_ack),
      .io_rdata  (io_rdata),
      .io_timeout(io_timeout),
      .d_iord    (d_iord),
      .d_iowr    (d_iowr),
      .d_io_8    (d_io_8),
      .d_io_16   (d_io_16),
      .d_io_addr (d_io_addr),
      .d_io_dbus (d_io_dbus),
      .d_ready_n (d_ready_n),
      .d_rdata   (d_rdata),
      .busy      (busy)
   );

   initial h_hclk = 1'b0;
   always #5 h_hclk = ~h_hclk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkIdle(input string name);
      checkVal({name, ".busy"}, busy, 0);
      checkVal({name, ".strobe"}, {d_iord, d_iowr}, 0);
      checkVal({name, ".ack"}, io_ack, 0);
   endtask

   // Outputs expected during one cycle of an in-flight access.
   task automatic checkOutput(input cyc_t e);
      checkVal("busy", busy, 1);
      checkVal("iord", d_iord, (e.kind == K_STB) && !cur.wr);
      checkVal("iowr", d_iowr, (e.kind == K_STB) && cur.wr);
      checkVal("ack", io_ack, e.kind == K_ACK);
      checkVal("timeout", io_timeout, (e.kind == K_ACK) && curTo);
      if (e.kind != K_ACK) begin
         checkVal("io8", d_io_8, 1);
         checkVal("io16", d_io_16, 0);
         checkVal("addr", d_io_addr, e.addr);
         if (cur.wr) checkVal("dbus", d_io_dbus, {e.db, e.db});
      end else if (!cur.wr) begin
         checkVal("rdata", io_rdata, curRd);
      end
   endtask

   // Decoder responder plus junk on host inputs that must be ignored mid-access.
   task automatic applyStimulus(input cyc_t e);
      int rd;
      io_req    = 1'($urandom);
      io_wr     = 1'($urandom);
      io_size16 = 1'($urandom);
      io_addr   = 16'($urandom);
      io_wdata  = 16'($urandom);
      if (e.kind == K_STB) begin
         rd        = (e.sub == 0) ? cur.rdly0 : cur.rdly1;
         d_ready_n = (e.stbNum >= rd) ? 1'b0 : 1'b1;
         d_rdata   = {8'($urandom), (e.sub == 0) ? cur.rb0 : cur.rb1};
      end else begin
         d_ready_n = 1'($urandom);
         d_rdata   = 16'($urandom);
      end
   endtask

   task automatic runTxn(input txn_t t, output int ackAt, output logic [15:0] rd, output logic toSeen);
      cyc_t        e;
      int          nsub;
      int          r;
      int          hold;
      int          len;
      logic [7:0]  bytes0;
      logic [7:0]  bytes1;
      logic [15:0] a;
      cur   = t;
      nsub  = t.s16 ? 2 : 1;
      curTo = 1'b0;
      bytes0 = 8'h00;
      bytes1 = 8'h00;
      expQ.delete();
      e = '{kind: K_SETUP, sub: 0, stbNum: 0, addr: t.addr, db: t.wdata[7:0]};
      expQ.push_back(e);
      for (int k = 0; k < nsub; k++) begin
         r    = (k == 0) ? t.rdly0 : t.rdly1;
         hold = (r > MIN_STB) ? r : MIN_STB;
         len  = (hold > TO_CYCLES) ? TO_CYCLES : hold;
         a    = t.addr + 16'(k);
         if (hold > TO_CYCLES) curTo = 1'b1;
         if (k == 0) bytes0 = (hold > TO_CYCLES) ? 8'hFF : t.rb0;
         else        bytes1 = (hold > TO_CYCLES) ? 8'hFF : t.rb1;
         for (int n = 1; n <= len; n++) begin
            e = '{kind: K_STB, sub: k, stbNum: n, addr: a,
                  db: (k == 0) ? t.wdata[7:0] : t.wdata[15:8]};
            expQ.push_back(e);
         end
         if (k == 0 && nsub == 2) begin
            e = '{kind: K_GAP, sub: 1, stbNum: 0, addr: t.addr + 16'd1, db: t.wdata[15:8]};
            expQ.push_back(e);
         end
      end
      e = '{kind: K_ACK, sub: 0, stbNum: 0, addr: 16'h0, db: 8'h0};
      expQ.push_back(e);
      curRd = {bytes1, bytes0};

      ackAt  = -1;
      rd     = 16'hxxxx;
      toSeen = 1'b0;
      @(negedge h_hclk);
      checkIdle("reqCycle");
      io_req    = 1'b1;
      io_wr     = t.wr;
      io_size16 = t.s16;
      io_addr   = t.addr;
      io_wdata  = t.wdata;
      d_ready_n = 1'($urandom);
      for (int i = 0; i < expQ.size(); i++) begin
         @(negedge h_hclk);
         checkOutput(expQ[i]);
         if (io_ack === 1'b1 && ackAt < 0) begin
            ackAt  = i + 1;
            rd     = io_rdata;
            toSeen = io_timeout;
         end
         applyStimulus(expQ[i]);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge h_hclk);
         checkIdle("idle");
         io_req    = 1'b0;
         d_ready_n = 1'($urandom);
      end
   endtask

   initial begin
      txn_t        t;
      int          ackAt;
      logic [15:0] rd;
      logic        toSeen;
      testsRun    = 0;
      testsFailed = 0;
      h_reset_n   = 1'b1;
      io_req      = 1'b0;
      io_wr       = 1'b0;
      io_size16   = 1'b0;
      io_addr     = 16'h0;
      io_wdata    = 16'h0;
      d_ready_n   = 1'b1;
      d_rdata     = 16'h0;
      #1 h_reset_n = 1'b0;
      #11;
      checkVal("resetOutputs", {io_ack, io_timeout, d_iord, d_iowr, d_io_8, d_io_16, busy}, 0);
      checkVal("resetRdata", io_rdata, 16'h0);
      checkVal("resetAddr", d_io_addr, 16'h0);
      checkVal("resetDbus", d_io_dbus, 16'h0);
      @(negedge h_hclk);
      h_reset_n = 1'b1;
      idleCycles(1);

      t = '{wr: 1, s16: 0, addr: 16'h03D4, wdata: 16'h0011, rdly0: 2, rdly1: 2, rb0: 8'h0, rb1: 8'h0};
      runTxn(t, ackAt, rd, toSeen);
      checkVal("wr8.ackLatency", ackAt, 4);
      checkVal("wr8.timeout", toSeen, 0);

      t = '{wr: 1, s16: 1, addr: 16'h03D4, wdata: 16'h2A11, rdly0: 2, rdly1: 2, rb0: 8'h0, rb1: 8'h0};
      runTxn(t, ackAt, rd, toSeen);
      checkVal("wr16.ackLatency", ackAt, 7);

      t = '{wr: 0, s16: 1, addr: 16'h03B4, wdata: 16'h0, rdly0: 1, rdly1: 3, rb0: 8'h05, rb1: 8'hC3};
      runTxn(t, ackAt, rd, toSeen);
      checkVal("rd16.rdata", rd, 16'hC305);

      t = '{wr: 0, s16: 0, addr: 16'h03B5, wdata: 16'h0, rdly0: NEVER, rdly1: NEVER, rb0: 8'h5A, rb1: 8'h0};
      runTxn(t, ackAt, rd, toSeen);
      checkVal("rdTimeout.rdata", rd, 16'h00FF);
      checkVal("rdTimeout.flag", toSeen, 1);
      checkVal("rdTimeout.ackLatency", ackAt, 66);

      t = '{wr: 1, s16: 1, addr: 16'hFFFF, wdata: 16'hBEEF, rdly0: 3, rdly1: 1, rb0: 8'h0, rb1: 8'h0};
      runTxn(t, ackAt, rd, toSeen);
      checkVal("wrapWrite.ackLatency", ackAt, 8);

      // Async reset in the middle of a split write strobe.
      @(negedge h_hclk);
      io_req = 1'b1; io_wr = 1'b1; io_size16 = 1'b1; io_addr = 16'h03D4; io_wdata = 16'h2A11;
      d_ready_n = 1'b1;
      @(negedge h_hclk);
      io_req = 1'b0;
      @(negedge h_hclk);
      checkVal("preReset.iowr", d_iowr, 1);
      #2 h_reset_n = 1'b0;
      #1;
      checkVal("midReset.strobes", {d_iord, d_iowr, d_io_8, busy}, 0);
      checkVal("midReset.rdata", io_rdata, 16'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge h_hclk);
         checkVal("midReset.noAck", {io_ack, busy}, 0);
      end
      h_reset_n = 1'b1;
      idleCycles(1);
      t = '{wr: 0, s16: 0, addr: 16'h03C5, wdata: 16'h0, rdly0: 2, rdly1: 2, rb0: 8'h7E, rb1: 8'h0};
      runTxn(t, ackAt, rd, toSeen);
      checkVal("postReset.ackLatency", ackAt, 4);
      checkVal("postReset.rdata", rd, 16'h007E);

      for (int n = 0; n < 40; n++) begin
         t.wr    = 1'($urandom);
         t.s16   = 1'($urandom);
         t.addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         t.wdata = 16'($urandom);
         t.rdly0 = $urandom_range(0, 9);
         t.rdly1 = $urandom_range(0, 9);
         if (t.rdly0 == 0) t.rdly0 = NEVER;
         if (t.rdly1 == 0) t.rdly1 = NEVER;
         t.rb0   = 8'($urandom);
         t.rb1   = 8'($urandom);
         idleCycles($urandom_range(0, 2));
         runTxn(t, ackAt, rd, toSeen);
      end
      idleCycles(2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
